// File: rtl/apple_spawn_ctrl.sv
// Apple respawn sequencer: eat detect, candidate sampling, wall/head/body checks, fallback to home.
// Latency: apple_valid returns 4 edges after the eating tick on a first-cycle clean ack; no backpressure beyond occ_ack.
module apple_spawn_ctrl #(
    parameter logic [10:0] INIT_X    = 11'd48,
    parameter logic [10:0] INIT_Y    = 11'd16,
    parameter int          MAX_TRIES = 8,
    parameter int          ACK_TMO   = 16,
    parameter int          SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               btnrst,
    input  logic               tick,
    input  logic [10:0]        snakehead_x,
    input  logic [10:0]        snakehead_y,
    input  logic [10:0]        wallpos_x,
    input  logic [10:0]        wallpos_y,
    input  logic [10:0]        cand_x,
    input  logic [10:0]        cand_y,
    output logic               occ_req,
    output logic [10:0]        occ_x,
    output logic [10:0]        occ_y,
    input  logic               occ_ack,
    input  logic               occ_hit,
    output logic [10:0]        apple_x,
    output logic [10:0]        apple_y,
    output logic               apple_valid,
    output logic               eaten,
    output logic               spawn_fail,
    output logic [SCORE_W-1:0] score
);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int TMO_W   = $clog2(ACK_TMO + 1);

    typedef enum logic [2:0] {HOLD, SAMPLE, CHECK, QUERY, COMMIT} state_t;

    // Reset asserts asynchronously and releases on a clock edge.
    logic rst_meta_q, rst_q;
    always_ff @(posedge clk or posedge btnrst) begin
        if (btnrst) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    state_t             state_q, state_d;
    logic [10:0]        cx_q, cx_d, cy_q, cy_d;
    logic [TRIES_W-1:0] tries_q, tries_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               occ_req_q, occ_req_d;
    logic [10:0]        occ_x_q, occ_x_d, occ_y_q, occ_y_d;
    logic [10:0]        apple_x_q, apple_x_d, apple_y_q, apple_y_d;
    logic               apple_valid_q, apple_valid_d;
    logic               eaten_q, eaten_d;
    logic               spawn_fail_q, spawn_fail_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               reject;

    always_comb begin
        state_d       = state_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        tries_d       = tries_q;
        tmo_d         = tmo_q;
        occ_req_d     = occ_req_q;
        occ_x_d       = occ_x_q;
        occ_y_d       = occ_y_q;
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        score_d       = score_q;
        eaten_d       = 1'b0;
        spawn_fail_d  = 1'b0;
        reject        = 1'b0;

        case (state_q)
            HOLD: begin
                if (tick && apple_valid_q &&
                    snakehead_x == apple_x_q && snakehead_y == apple_y_q) begin
                    eaten_d       = 1'b1;
                    apple_valid_d = 1'b0;
                    score_d       = (score_q == '1) ? score_q : score_q + 1'b1;
                    tries_d       = '0;
                    state_d       = SAMPLE;
                end
            end
            SAMPLE: begin
                cx_d    = cand_x;
                cy_d    = cand_y;
                state_d = CHECK;
            end
            CHECK: begin
                if ((cx_q == wallpos_x   && cy_q == wallpos_y)   ||
                    (cx_q == snakehead_x && cy_q == snakehead_y) ||
                    (cx_q == apple_x_q   && cy_q == apple_y_q)) begin
                    reject = 1'b1;
                end else begin
                    occ_req_d = 1'b1;
                    occ_x_d   = cx_q;
                    occ_y_d   = cy_q;
                    tmo_d     = '0;
                    state_d   = QUERY;
                end
            end
            QUERY: begin
                if (occ_ack) begin
                    occ_req_d = 1'b0;
                    if (occ_hit) reject = 1'b1;
                    else         state_d = COMMIT;
                end else if (tmo_q == TMO_W'(ACK_TMO - 1)) begin
                    occ_req_d = 1'b0;
                    reject    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            COMMIT: begin
                apple_x_d     = cx_q;
                apple_y_d     = cy_q;
                apple_valid_d = 1'b1;
                state_d       = HOLD;
            end
            default: state_d = HOLD;
        endcase

        // Out of attempts: commit the home tile instead of sampling again.
        if (reject) begin
            if (tries_q == TRIES_W'(MAX_TRIES - 1)) begin
                cx_d         = INIT_X;
                cy_d         = INIT_Y;
                spawn_fail_d = 1'b1;
                state_d      = COMMIT;
            end else begin
                tries_d = tries_q + 1'b1;
                state_d = SAMPLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_q) begin
        if (rst_q) begin
            state_q       <= HOLD;
            cx_q          <= '0;
            cy_q          <= '0;
            tries_q       <= '0;
            tmo_q         <= '0;
            occ_req_q     <= 1'b0;
            occ_x_q       <= '0;
            occ_y_q       <= '0;
            apple_x_q     <= INIT_X;
            apple_y_q     <= INIT_Y;
            apple_valid_q <= 1'b1;
            eaten_q       <= 1'b0;
            spawn_fail_q  <= 1'b0;
            score_q       <= '0;
        end else begin
            state_q       <= state_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            tries_q       <= tries_d;
            tmo_q         <= tmo_d;
            occ_req_q     <= occ_req_d;
            occ_x_q       <= occ_x_d;
            occ_y_q       <= occ_y_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            eaten_q       <= eaten_d;
            spawn_fail_q  <= spawn_fail_d;
            score_q       <= score_d;
        end
    end

    assign occ_req     = occ_req_q;
    assign occ_x       = occ_x_q;
    assign occ_y       = occ_y_q;
    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;
    assign apple_valid = apple_valid_q;
    assign eaten       = eaten_q;
    assign spawn_fail  = spawn_fail_q;
    assign score       = score_q;
endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: directed scenarios plus randomized eat episodes against an attempt-level model.
module tb_apple_spawn_ctrl;
    localparam logic [10:0] INIT_X = 11'd48;
    localparam logic [10:0] INIT_Y = 11'd16;
    localparam int MAX_TRIES = 8;
    localparam int ACK_TMO   = 16;
    localparam int N         = 512;

    logic        clk = 1'b0;
    logic        btnrst, tick, occ_ack, occ_hit;
    logic [10:0] head_x, head_y, wall_x, wall_y, cand_x, cand_y;
    logic        occ_req, apple_valid, eaten, spawn_fail;
    logic [10:0] occ_x, occ_y, apple_x, apple_y;
    logic [7:0]  score;

    apple_spawn_ctrl dut (
        .clk(clk), .btnrst(btnrst), .tick(tick),
        .snakehead_x(head_x), .snakehead_y(head_y),
        .wallpos_x(wall_x), .wallpos_y(wall_y),
        .cand_x(cand_x), .cand_y(cand_y),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_ack(occ_ack), .occ_hit(occ_hit),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .eaten(eaten), .spawn_fail(spawn_fail), .score(score)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Per-edge plan of one episode; index k = k-th rising edge after (and including) the eating tick.
    logic [10:0] pc_x [N];
    logic [10:0] pc_y [N];
    logic [10:0] e_qx [N];
    logic [10:0] e_qy [N];
    bit          p_ack [N];
    bit          p_hit [N];
    bit          e_req [N];
    bit          in_q  [N];
    int          c_edge, f_edge;
    logic [10:0] m_ax, m_ay, n_ax, n_ay;
    int          m_score;
    logic [21:0] q_cand [$];
    int          q_kind [$];
    int          q_dly  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // kind: 0 = ack clean, 1 = ack hit, 2 = never ack. Attempts that fail wall/head/apple never query.
    task automatic plan_episode();
        int e, tries, kind, d, dec;
        int unsigned r;
        logic [10:0] cx, cy;
        bit done;
        for (int k = 0; k < N; k++) begin
            pc_x[k] = 11'($urandom); pc_y[k] = 11'($urandom);
            p_ack[k] = 1'b0; p_hit[k] = 1'($urandom);
            e_req[k] = 1'b0; in_q[k] = 1'b0;
            e_qx[k] = '0; e_qy[k] = '0;
        end
        e = 1; tries = 0; done = 1'b0; f_edge = -1; c_edge = 0; kind = 0; d = 0;
        while (!done) begin
            if (q_cand.size() > 0) begin
                {cx, cy} = q_cand.pop_front();
            end else begin
                r = $urandom_range(7);
                if (r == 0)      begin cx = wall_x; cy = wall_y; end
                else if (r == 1) begin cx = head_x; cy = head_y; end
                else             begin cx = 11'($urandom); cy = 11'($urandom); end
            end
            pc_x[e] = cx; pc_y[e] = cy;
            if ((cx == wall_x && cy == wall_y) || (cx == head_x && cy == head_y) ||
                (cx == m_ax && cy == m_ay)) begin
                kind = 1; dec = e + 1;
            end else begin
                if (q_kind.size() > 0) begin
                    kind = q_kind.pop_front(); d = q_dly.pop_front();
                end else begin
                    r = $urandom_range(9);
                    kind = (r < 5) ? 1 : (r < 9) ? 0 : 2;
                    d = int'($urandom_range(3));
                end
                dec = (kind == 2) ? e + 1 + ACK_TMO : e + 2 + d;
                for (int j = e + 1; j < dec; j++) begin
                    e_req[j] = 1'b1; e_qx[j] = cx; e_qy[j] = cy;
                end
                for (int j = e + 2; j <= dec; j++) in_q[j] = 1'b1;
                if (kind != 2) begin
                    p_ack[dec] = 1'b1; p_hit[dec] = (kind == 1);
                end
            end
            if (kind == 0) begin
                n_ax = cx; n_ay = cy; c_edge = dec + 1; done = 1'b1;
            end else if (tries == MAX_TRIES - 1) begin
                n_ax = INIT_X; n_ay = INIT_Y; f_edge = dec; c_edge = dec + 1; done = 1'b1;
            end else begin
                tries++; e = dec + 1;
            end
        end
        // Stray acks where no query is outstanding must be ignored.
        for (int k = 0; k <= c_edge; k++)
            if (!in_q[k] && $urandom_range(3) == 0) p_ack[k] = 1'b1;
    endtask

    task automatic drive_edge(input int k, input bit tk);
        tick = tk; cand_x = pc_x[k]; cand_y = pc_y[k];
        occ_ack = p_ack[k]; occ_hit = p_hit[k];
        @(posedge clk); #1;
    endtask

    task automatic run_episode(input string tag);
        logic [10:0] ox, oy;
        head_x = m_ax; head_y = m_ay;
        plan_episode();
        ox = m_ax; oy = m_ay;
        m_score = (m_score < 255) ? m_score + 1 : 255;
        for (int k = 0; k <= c_edge; k++) begin
            drive_edge(k, (k <= 1) ? 1'b1 : 1'($urandom));
            chk({tag, "_req"}, occ_req, e_req[k]);
            if (e_req[k]) begin
                chk({tag, "_qx"}, occ_x, e_qx[k]);
                chk({tag, "_qy"}, occ_y, e_qy[k]);
            end
            chk({tag, "_eaten"}, eaten, (k == 0));
            chk({tag, "_fail"}, spawn_fail, (k == f_edge));
            chk({tag, "_valid"}, apple_valid, (k >= c_edge));
            chk({tag, "_ax"}, apple_x, (k >= c_edge) ? n_ax : ox);
            chk({tag, "_ay"}, apple_y, (k >= c_edge) ? n_ay : oy);
            chk({tag, "_score"}, score, m_score);
        end
        tick = 1'b0; occ_ack = 1'b0;
        m_ax = n_ax; m_ay = n_ay;
    endtask

    initial begin
        btnrst = 1'b1; tick = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
        head_x = '0; head_y = '0; wall_x = '0; wall_y = '0; cand_x = '0; cand_y = '0;
        m_ax = INIT_X; m_ay = INIT_Y; m_score = 0;
        repeat (3) @(posedge clk);
        #1 btnrst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_ax", apple_x, INIT_X);
        chk("rst_ay", apple_y, INIT_Y);
        chk("rst_valid", apple_valid, 1);
        chk("rst_score", score, 0);
        chk("rst_req", occ_req, 0);
        chk("rst_eaten", eaten, 0);

        // A tick with the head elsewhere does nothing.
        head_x = 11'd49; head_y = INIT_Y; tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        chk("miss_eaten", eaten, 0);
        chk("miss_valid", apple_valid, 1);
        chk("miss_score", score, 0);

        wall_x = 11'd0; wall_y = 11'd0;
        q_cand.push_back({11'd400, 11'd208}); q_kind.push_back(0); q_dly.push_back(0);
        run_episode("t2");
        chk("t2_cedge", c_edge, 4);
        chk("t2_score1", score, 1);

        wall_x = 11'd400; wall_y = 11'd208;
        q_cand.push_back({11'd400, 11'd208});
        q_cand.push_back({11'd432, 11'd272}); q_kind.push_back(0); q_dly.push_back(1);
        run_episode("t3");
        chk("t3_ax", apple_x, 432);
        chk("t3_ay", apple_y, 272);

        for (int i = 0; i < MAX_TRIES; i++) begin
            q_cand.push_back({11'(100 + 32 * i), 11'd50});
            q_kind.push_back((i < MAX_TRIES - 1) ? 1 : 2);
            q_dly.push_back(i % 3);
        end
        run_episode("t4");
        chk("t4_fedge", f_edge >= 0, 1);
        chk("t4_ax", apple_x, INIT_X);
        chk("t4_ay", apple_y, INIT_Y);

        // Reset while a query is outstanding.
        head_x = m_ax; head_y = m_ay;
        q_cand.push_back({11'd600, 11'd300}); q_kind.push_back(2); q_dly.push_back(0);
        plan_episode();
        for (int k = 0; k <= 2; k++) drive_edge(k, k == 0);
        chk("t5_req_up", occ_req, 1);
        #2 btnrst = 1'b1;
        #1;
        chk("t5_req_drop", occ_req, 0);
        chk("t5_ax", apple_x, INIT_X);
        chk("t5_ay", apple_y, INIT_Y);
        chk("t5_valid", apple_valid, 1);
        chk("t5_score", score, 0);
        tick = 1'b0; occ_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 btnrst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        m_ax = INIT_X; m_ay = INIT_Y; m_score = 0;
        chk("t5_rel_valid", apple_valid, 1);
        chk("t5_rel_req", occ_req, 0);

        // Randomized episodes, enough eats to saturate the score.
        for (int i = 0; i < 262; i++) begin
            if ($urandom_range(1) == 0) begin
                wall_x = 11'($urandom); wall_y = 11'($urandom);
            end
            run_episode("rnd");
        end
        chk("sat_score", score, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
